mem_copy_engine: RTL and testbench

Block-copy DMA engine sitting directly upstream of the single-port data memory. It owns the memory's address, enable and write-data inputs. When idle it passes CPU load/store requests straight through. When started it copies `len` bytes from `src` to `dst` as one read cycle followed by one write cycle per byte, and stalls the CPU until the copy finishes.

---
 rtl/mem_copy_engine.sv | 137 +++++++++++++
 tb/tb_mem_copy_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-copy DMA engine in front of a single-port data memory; passes CPU accesses through when idle.
// Define DMA_OVERLAP_EN to copy backwards on forward-overlapping ranges (memmove semantics).
module mem_copy_engine #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_read_en,
  input  logic          cpu_write_en,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read_en,
  output logic          mem_write_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_e;

  state_e        state_q;
  logic [AW-1:0] cur_src_q;
  logic [AW-1:0] cur_dst_q;
  logic [AW-1:0] count_q;
  logic [DW-1:0] buf_q;
  logic          dir_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] init_src_d;
  logic [AW-1:0] init_dst_d;
  logic          dir_d;

  // Start addresses and direction; overlap test is done one bit wider so src+len never wraps
  always_comb begin
    dir_d      = 1'b0;
    init_src_d = src;
    init_dst_d = dst;
`ifdef DMA_OVERLAP_EN
    dir_d = ({1'b0, dst} > {1'b0, src}) && ({1'b0, dst} < ({1'b0, src} + {1'b0, len}));
    if (dir_d) begin
      init_src_d = src + len - AW'(1);
      init_dst_d = dst + len - AW'(1);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cur_src_q <= init_src_d;
            cur_dst_q <= init_dst_d;
            count_q   <= len;
            dir_q     <= dir_d;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          buf_q   <= mem_rdata;
          state_q <= WRITE;
        end
        WRITE: begin
          cur_src_q <= dir_q ? cur_src_q - AW'(1) : cur_src_q + AW'(1);
          cur_dst_q <= dir_q ? cur_dst_q - AW'(1) : cur_dst_q + AW'(1);
          count_q   <= count_q - AW'(1);
          if (count_q == AW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port mux: engine owns the port in READ/WRITE, CPU otherwise
  always_comb begin
    mem_addr     = cpu_addr;
    mem_read_en  = cpu_read_en;
    mem_write_en = cpu_write_en;
    mem_wdata    = cpu_wdata;
    unique case (state_q)
      READ: begin
        mem_addr     = cur_src_q;
        mem_read_en  = 1'b1;
        mem_write_en = 1'b0;
        mem_wdata    = buf_q;
      end
      WRITE: begin
        mem_addr     = cur_dst_q;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b1;
        mem_wdata    = buf_q;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_stall = busy_q & (cpu_read_en | cpu_write_en);
  assign cpu_rdata = busy_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural memory, reference byte model and write scoreboard.
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       reset, start;
  logic [7:0] src, dst, len;
  logic       busy, done;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_read_en, cpu_write_en, cpu_stall;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_read_en, mem_write_en;

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int n_cmp = 0, n_fail = 0;
  int busy_cnt, first_busy, last_busy, done_cnt, first_done, stall_cnt, rdnz_cnt, en_cnt;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done),
    .cpu_addr(cpu_addr), .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_write_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1;
    @(negedge CLK);
    cpu_write_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference model: applies the first nb byte moves and queues the expected memory writes
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input int nb);
    bit back = 1'b0;
    logic [7:0] j, as, ad;
`ifdef DMA_OVERLAP_EN
    back = ({1'b0, d} > {1'b0, s}) && ({1'b0, d} < ({1'b0, s} + {1'b0, l}));
`endif
    for (int k = 0; k < nb; k++) begin
      j  = back ? 8'(int'(l) - 1 - k) : 8'(k);
      as = s + j;
      ad = d + j;
      ref_mem[ad] = ref_mem[as];
      exp_q.push_back({ad, ref_mem[as]});
    end
  endtask

  // Starts a copy and records per-cycle observations for ncyc cycles after the accepting edge
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int ncyc, input int rst_at, input int restart_at);
    busy_cnt = 0; first_busy = 0; last_busy = 0; done_cnt = 0; first_done = 0;
    stall_cnt = 0; rdnz_cnt = 0; en_cnt = 0;
    @(negedge CLK);
    start = 1'b1; src = s; dst = d; len = l;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge CLK);
      start = (i == restart_at);
      if (i == restart_at) begin src = 8'h00; dst = 8'hC0; len = 8'h08; end
      reset = (i == rst_at);
      #1;
      if (busy === 1'b1) begin
        busy_cnt++; last_busy = i;
        if (first_busy == 0) first_busy = i;
        if (cpu_stall === 1'b1) stall_cnt++;
        if (cpu_rdata !== 8'h00) rdnz_cnt++;
        if (mem_write_en === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
      if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) en_cnt++;
    end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    cpu_addr = 8'h33; cpu_read_en = 1'b1; cpu_write_en = 1'b0; cpu_wdata = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    n_cmp++; if (mem_addr !== 8'h33 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_passthru: got addr=%h re=%b we=%b want 33/1/0", mem_addr, mem_read_en, mem_write_en);
    end
    @(negedge CLK);
    reset = 1'b0; cpu_read_en = 1'b0;
  endtask

  task automatic test_passthrough;
    @(negedge CLK);
    cpu_addr = 8'h20; cpu_wdata = 8'h5A; cpu_write_en = 1'b1;
    #1;
    n_cmp++; if (mem_write_en !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h5A) begin
      n_fail++; $display("FAIL pt_store: got we=%b addr=%h wd=%h want 1/20/5a", mem_write_en, mem_addr, mem_wdata);
    end
    ref_mem[8'h20] = 8'h5A;
    @(negedge CLK);
    cpu_write_en = 1'b0; cpu_read_en = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL pt_load: got %h want 5a", cpu_rdata); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL pt_stall: got %b want 0", cpu_stall); end
    @(negedge CLK);
    cpu_read_en = 1'b0;
  endtask

  task automatic test_basic_copy;
    logic [15:0] e, o;
    logic [7:0] want [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 4; k++) cpu_store(8'h10 + 8'(k), want[k]);
    model_copy(8'h10, 8'h80, 8'd4, 4);
    run_copy(8'h10, 8'h80, 8'd4, 12, 0, 0);
    n_cmp++; if (first_busy != 1 || last_busy != 8 || busy_cnt != 8) begin
      n_fail++; $display("FAIL basic_busy: got first=%0d last=%0d n=%0d want 1/8/8", first_busy, last_busy, busy_cnt);
    end
    n_cmp++; if (first_done != 9 || done_cnt != 1) begin
      n_fail++; $display("FAIL basic_done: got cycle=%0d n=%0d want 9/1", first_done, done_cnt);
    end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL basic_wr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[8'h80 + 8'(k)] !== want[k]) begin
        n_fail++; $display("FAIL basic_mem[%0d]: got %h want %h", k, mem[8'h80 + 8'(k)], want[k]);
      end
    end
  endtask

  task automatic test_zero_len_and_restart;
    logic [15:0] e, o;
    run_copy(8'h10, 8'h90, 8'd0, 4, 0, 0);
    n_cmp++; if (first_done != 1 || done_cnt != 1 || busy_cnt != 0) begin
      n_fail++; $display("FAIL zero_done: got cycle=%0d n=%0d busy=%0d want 1/1/0", first_done, done_cnt, busy_cnt);
    end
    n_cmp++; if (en_cnt != 0) begin n_fail++; $display("FAIL zero_enables: got %0d want 0", en_cnt); end
    cpu_store(8'hC0, 8'h77);
    model_copy(8'h10, 8'hA0, 8'd2, 2);
    run_copy(8'h10, 8'hA0, 8'd2, 10, 0, 2);
    n_cmp++; if (busy_cnt != 4 || first_done != 5 || done_cnt != 1) begin
      n_fail++; $display("FAIL restart_timing: got busy=%0d done@%0d n=%0d want 4/5/1", busy_cnt, first_done, done_cnt);
    end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL restart_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL restart_wr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (mem[8'hC0] !== 8'h77) begin n_fail++; $display("FAIL restart_untouched: got %h want 77", mem[8'hC0]); end
  endtask

  task automatic test_wrap;
    logic [15:0] e, o;
    logic [7:0] want [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    cpu_store(8'hFE, want[0]); cpu_store(8'hFF, want[1]);
    cpu_store(8'h00, want[2]); cpu_store(8'h01, want[3]);
    model_copy(8'hFE, 8'h40, 8'd4, 4);
    run_copy(8'hFE, 8'h40, 8'd4, 12, 0, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wrap_wr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[8'h40 + 8'(k)] !== want[k]) begin
        n_fail++; $display("FAIL wrap_mem[%0d]: got %h want %h", k, mem[8'h40 + 8'(k)], want[k]);
      end
    end
  endtask

  task automatic test_overlap;
    logic [15:0] e, o;
`ifdef DMA_OVERLAP_EN
    logic [7:0] want [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
`else
    logic [7:0] want [4] = '{8'd1, 8'd2, 8'd1, 8'd2};
`endif
    for (int k = 0; k < 4; k++) cpu_store(8'h10 + 8'(k), 8'(k + 1));
    model_copy(8'h10, 8'h12, 8'd4, 4);
    run_copy(8'h10, 8'h12, 8'd4, 12, 0, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovl_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL ovl_wr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[8'h12 + 8'(k)] !== want[k]) begin
        n_fail++; $display("FAIL ovl_mem[%0d]: got %h want %h", k, mem[8'h12 + 8'(k)], want[k]);
      end
    end
  endtask

  task automatic test_stall_reset;
    logic [15:0] e, o;
    for (int k = 0; k < 4; k++) cpu_store(8'h30 + 8'(k), 8'(9 - k));
    for (int k = 0; k < 4; k++) cpu_store(8'h60 + 8'(k), 8'hEE);
    @(negedge CLK);
    cpu_addr = 8'h30; cpu_read_en = 1'b1;
    model_copy(8'h30, 8'h60, 8'd4, 2);
    run_copy(8'h30, 8'h60, 8'd4, 12, 5, 0);
    n_cmp++; if (busy_cnt != 5 || stall_cnt != 5) begin
      n_fail++; $display("FAIL stall_cycles: got busy=%0d stall=%0d want 5/5", busy_cnt, stall_cnt);
    end
    n_cmp++; if (rdnz_cnt != 0) begin n_fail++; $display("FAIL stall_rdata: got %0d nonzero want 0", rdnz_cnt); end
    n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); end
    #1;
    n_cmp++; if (busy !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 8'h09) begin
      n_fail++; $display("FAIL rst_idle: got busy=%b stall=%b rd=%h want 0/0/09", busy, cpu_stall, cpu_rdata);
    end
    cpu_read_en = 1'b0;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rst_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rst_wr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (mem[8'h60] !== 8'h09 || mem[8'h61] !== 8'h08 || mem[8'h62] !== 8'hEE || mem[8'h63] !== 8'hEE) begin
      n_fail++; $display("FAIL rst_mem: got %h %h %h %h want 09 08 ee ee", mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    test_reset();
    test_passthrough();
    test_basic_copy();
    test_zero_len_and_restart();
    test_wrap();
    test_overlap();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
